// File: rtl/mux_gate_arbiter.sv
// -----------------------------------------------------------------------------
// mux_gate_arbiter
//
// Shares one W-bit bitwise logic unit among NREQ requesters. Every result bit
// comes from a 2:1 mux cell selected by the matching bit of operand A. A
// round-robin arbiter grants at most one request per cycle. The registered
// result goes back over a valid/ready response channel, tagged with the
// requester ID.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   req_valid  in   NREQ    request pending, one bit per requester
//   req_ready  out  NREQ    grant, one-hot or zero
//   req_op     in   3*NREQ  opcode of requester i at [3i+2:3i]
//   req_a      in   W*NREQ  operand A of requester i at [Wi+W-1:Wi]
//   req_b      in   W*NREQ  operand B of requester i (ignored for NOT)
//   rsp_valid  out  1       response holds a result
//   rsp_ready  in   1       consumer accepts the response
//   rsp_id     out  IDW     requester that owns rsp_data
//   rsp_data   out  W       result
//   rsp_err    out  1       the opcode was illegal
// -----------------------------------------------------------------------------
module mux_gate_arbiter #(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [3*NREQ-1:0] req_op,
   input  logic [W*NREQ-1:0] req_a,
   input  logic [W*NREQ-1:0] req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [W-1:0]      rsp_data,
   output logic              rsp_err
);

   typedef enum logic [2:0] {
      OP_NOT  = 3'd0,
      OP_AND  = 3'd1,
      OP_OR   = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XOR  = 3'd5,
      OP_XNOR = 3'd6,
      OP_ILL  = 3'd7
   } op_e;

   // Mux-gate datapath: bit k = a[k] ? in1[k] : in0[k]. The opcode only
   // chooses which constants / B polarity feed the two mux inputs.
   function automatic logic [W-1:0] mux_gate(input op_e op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      logic [W-1:0] in0;
      logic [W-1:0] in1;
      logic [W-1:0] res;
      in0 = '0;
      in1 = '0;
      res = '0;
      case (op)
         OP_NOT:  begin in0 = '1; in1 = '0; end
         OP_AND:  begin in0 = '0; in1 = b;  end
         OP_OR:   begin in0 = b;  in1 = '1; end
         OP_NAND: begin in0 = '1; in1 = ~b; end
         OP_NOR:  begin in0 = ~b; in1 = '0; end
         OP_XOR:  begin in0 = b;  in1 = ~b; end
         OP_XNOR: begin in0 = ~b; in1 = b;  end
         default: begin in0 = '0; in1 = '0; end
      endcase
      for (int k = 0; k < W; k++) begin
         res[k] = a[k] ? in1[k] : in0[k];
      end
      return res;
   endfunction

   // Controller state {ptr, rsp_valid} plus the registered response.
   logic [IDW-1:0] ptr_q,       ptr_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0] rsp_id_q,    rsp_id_d;
   logic [W-1:0]   rsp_data_q,  rsp_data_d;
   logic           rsp_err_q,   rsp_err_d;

   logic           free;
   logic           gnt_found;
   logic [IDW-1:0] gnt_idx;
   logic [2:0]     gnt_op;
   logic [W-1:0]   gnt_a;
   logic [W-1:0]   gnt_b;

   // Gated by rst_n so no grant is offered while reset is held.
   assign free = rst_n & (~rsp_valid_q | rsp_ready);

   // Round-robin search: pass 0 scans ptr..NREQ-1, pass 1 wraps to 0..ptr-1.
   // The first hit wins, which is the same as scanning ptr, ptr+1, ... mod NREQ.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path leaves it unassigned and no latch is inferred.
      gnt_found = 1'b0;
      gnt_idx   = '0;
      gnt_op    = '0;
      gnt_a     = '0;
      gnt_b     = '0;
      req_ready = '0;
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found && free && req_valid[i] &&
                ((pass == 0) == (i >= int'(ptr_q)))) begin
               gnt_found    = 1'b1;
               gnt_idx      = IDW'(i);
               gnt_op       = req_op[3*i +: 3];
               gnt_a        = req_a[W*i +: W];
               gnt_b        = req_b[W*i +: W];
               req_ready[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ptr_d       = ptr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      if (gnt_found) begin
         // A grant implies the slot is free, so a pending result is popped and
         // replaced on the same edge.
         rsp_valid_d = 1'b1;
         rsp_id_d    = gnt_idx;
         rsp_err_d   = (op_e'(gnt_op) == OP_ILL);
         rsp_data_d  = mux_gate(op_e'(gnt_op), gnt_a, gnt_b);
         ptr_d       = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end else if (rsp_ready) begin
         // Pop without refill: ID and data keep their last values.
         rsp_valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments only, so every flop
   // samples the pre-edge value of its _d input regardless of block order.
   // NOTE: the response payload is reset too, not just rsp_valid, because its
   // reset value of zero is visible on the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mux_gate_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_gate_arbiter
//
// Self-checking bench for mux_gate_arbiter (NREQ=4, W=8). A behavioural model
// tracks the response slot and the round-robin pointer as plain integers and
// computes results with ordinary bitwise operators. A compare process checks
// every DUT output against the model on each falling edge. Directed phases add
// literal expectations (truth table, illegal op, round-robin order,
// backpressure, reset), followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_mux_gate_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_ready;
   logic [3*NREQ-1:0] req_op = '0;
   logic [W*NREQ-1:0] req_a = '0;
   logic [W*NREQ-1:0] req_b = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_data;
   logic              rsp_err;

   int total = 0;
   int bad   = 0;

   mux_gate_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit           m_valid = 1'b0;
   logic [W-1:0] m_data  = '0;
   int           m_id    = 0;
   bit           m_err   = 1'b0;
   int           m_ptr   = 0;

   function automatic logic [W-1:0] op_result(input int op,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      case (op)
         0:       return ~a;
         1:       return a & b;
         2:       return a | b;
         3:       return ~(a & b);
         4:       return ~(a | b);
         5:       return a ^ b;
         6:       return ~(a ^ b);
         default: return '0;
      endcase
   endfunction

   // Requester the model expects to be granted now, or -1.
   function automatic int pick();
      if (!(rst_n && (!m_valid || rsp_ready))) return -1;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (m_ptr + k) % NREQ;
         if (req_valid[idx]) return idx;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int g;
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_data  <= '0;
         m_id    <= 0;
         m_err   <= 1'b0;
         m_ptr   <= 0;
      end else begin
         g = pick();
         if (g >= 0) begin
            m_valid <= 1'b1;
            m_id    <= g;
            m_err   <= (int'(req_op[3*g +: 3]) == 7);
            m_data  <= op_result(int'(req_op[3*g +: 3]), req_a[W*g +: W], req_b[W*g +: W]);
            m_ptr   <= (g + 1) % NREQ;
         end else if (rsp_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      int g;
      logic [NREQ-1:0] exp_rdy;
      g = pick();
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      check("rsp_id",    32'(rsp_id),    32'(m_id));
      check("rsp_data",  32'(rsp_data),  32'(m_data));
      check("rsp_err",   32'(rsp_err),   32'(m_err));
   end

   // ---------------- stimulus ----------------
   task automatic set_req(input int i, input bit v, input int op,
                          input logic [W-1:0] a, input logic [W-1:0] b);
      req_valid[i]      = v;
      req_op[3*i +: 3]  = 3'(op);
      req_a[W*i +: W]   = a;
      req_b[W*i +: W]   = b;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [W-1:0] tt [7] = '{8'h0F, 8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3};
   int exp_ids [6]      = '{0, 1, 2, 3, 0, 1};
   int rr_ids  [4]      = '{1, 3, 1, 3};

   initial begin
      // Reset values while rst_n is held.
      repeat (2) step();
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_req_ready", 32'(req_ready), 32'd0);
      req_valid = '1;
      #1;
      check("reset_req_ready_held", 32'(req_ready), 32'd0);
      req_valid = '0;
      step();
      rst_n = 1'b1;
      rsp_ready = 1'b1;

      // Truth table through requester 0 only.
      for (int op = 0; op < 7; op++) begin
         set_req(0, 1'b1, op, 8'hF0, 8'hCC);
         step();
         check($sformatf("tt_data_op%0d", op), 32'(rsp_data), 32'(tt[op]));
         check($sformatf("tt_id_op%0d", op),   32'(rsp_id),   32'd0);
         check($sformatf("tt_err_op%0d", op),  32'(rsp_err),  32'd0);
      end

      // Illegal opcode.
      set_req(0, 1'b1, 7, 8'hFF, 8'hFF);
      step();
      check("ill_data", 32'(rsp_data), 32'h00);
      check("ill_err",  32'(rsp_err),  32'd1);
      check("ill_valid", 32'(rsp_valid), 32'd1);
      set_req(0, 1'b0, 0, '0, '0);
      step();
      check("pop_valid", 32'(rsp_valid), 32'd0);

      // Requesters 1 and 3 only; ptr is 1 here, so order is 1,3,1,3.
      set_req(1, 1'b1, 1, 8'hAA, 8'h0F);
      set_req(3, 1'b1, 2, 8'h11, 8'h22);
      for (int n = 0; n < 4; n++) begin
         step();
         check($sformatf("rr_id%0d", n), 32'(rsp_id), 32'(rr_ids[n]));
      end

      // Backpressure with everyone pending.
      for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, i, 8'(8'h35 + i), 8'(8'h5A ^ i));
      rsp_ready = 1'b0;
      for (int n = 0; n < 5; n++) begin
         step();
         check($sformatf("bp_ready%0d", n), 32'(req_ready), 32'd0);
         check($sformatf("bp_valid%0d", n), 32'(rsp_valid), 32'd1);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_release_grant", 32'(req_ready != '0), 32'd1);

      // Stream, then async reset mid-stream.
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_data",  32'(rsp_data),  32'd0);
      check("rst_id",    32'(rsp_id),    32'd0);
      check("rst_err",   32'(rsp_err),   32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
      step();
      rst_n = 1'b1;
      for (int n = 0; n < 6; n++) begin
         step();
         check($sformatf("seq_id%0d", n), 32'(rsp_id), 32'(exp_ids[n]));
         check($sformatf("seq_valid%0d", n), 32'(rsp_valid), 32'd1);
      end

      // Randomized traffic; the compare process checks every cycle.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            set_req(i, ($urandom_range(0, 99) < 45), $urandom_range(0, 7),
                    8'($urandom), 8'($urandom));
         end
         rsp_ready = ($urandom_range(0, 99) < 70);
         step();
      end

      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (2) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
